// File: rtl/sd_clk_gen.sv
// sd_clk_gen: programmable SD bus clock generator in the clk_i domain.
// Divides clk_i by an even ratio 2*(D+1), where D is the active divider.
// The clock starts and stops without glitches. A new divider is taken up
// on a falling edge while running, or straight away while stopped.
// Ports:
//   clk_i       system clock (the only clock)
//   rst_i       synchronous active-high reset
//   clk_en_i    level request: 1 = run SDCLK, 0 = park SDCLK low
//   div_i       new divider value; half-period = div_i+1 cycles
//   div_load_i  one-cycle pulse that captures div_i into the pending slot
//   SDCLK_o     registered SD clock
//   rise_stb_o  high in the first cycle SDCLK_o reads 1
//   fall_stb_o  high in the first cycle SDCLK_o reads 0 after a high phase
//   div_ack_o   high in the first cycle a newly loaded divider is active
//   running_o   high while the generator is in RUN
module sd_clk_gen #(
    parameter int DIV_W    = 8,
    parameter int INIT_DIV = 199
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clk_en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             SDCLK_o,
    output logic             rise_stb_o,
    output logic             fall_stb_o,
    output logic             div_ack_o,
    output logic             running_o
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] INIT_VAL = DIV_W'(INIT_DIV);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_act_q;
    logic [DIV_W-1:0] div_act_d;
    logic [DIV_W-1:0] div_pend_q;
    logic [DIV_W-1:0] div_pend_d;
    logic             pend_q;
    logic             pend_d;
    logic             sdclk_q;
    logic             sdclk_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             ack_q;
    logic             ack_d;
    logic             tick;
    logic             apply;

    // End of the current half period.
    assign tick = (cnt_q == div_act_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        sdclk_d    = sdclk_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        ack_d      = 1'b0;
        apply      = 1'b0;

        unique case (state_q)
            STOP: begin
                sdclk_d = 1'b0;
                cnt_d   = '0;
                // Nothing is toggling, so a pending divider can go live now.
                apply   = pend_q;
                if (clk_en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!sdclk_q && !clk_en_i) begin
                    // Cutting a low phase short is harmless: the pin stays low.
                    state_d = STOP;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d   = '0;
                    sdclk_d = ~sdclk_q;
                    if (sdclk_q) begin
                        // Falling edge: the only safe point to swap dividers,
                        // and the point where a held stop request takes effect.
                        fall_d = 1'b1;
                        apply  = pend_q;
                        if (!clk_en_i) begin
                            state_d = STOP;
                        end
                    end else begin
                        rise_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = STOP;
            end
        endcase

        // Apply consumes the value pending before this edge.
        if (apply) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
        end

        // A load on the same edge refills the slot for the next apply.
        if (div_load_i) begin
            div_pend_d = div_i;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= STOP;
            cnt_q      <= '0;
            div_act_q  <= INIT_VAL;
            div_pend_q <= INIT_VAL;
            pend_q     <= 1'b0;
            sdclk_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            sdclk_q    <= sdclk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            ack_q      <= ack_d;
        end
    end

    assign SDCLK_o    = sdclk_q;
    assign rise_stb_o = rise_q;
    assign fall_stb_o = fall_q;
    assign div_ack_o  = ack_q;
    assign running_o  = (state_q == RUN);

endmodule

// File: tb/tb_sd_clk_gen.sv
// tb_sd_clk_gen: scoreboard bench for sd_clk_gen.
// A phase-countdown reference model queues the expected outputs each
// cycle; a monitor pops and compares them. Directed phase checks are added.
module tb_sd_clk_gen;

    localparam int DIV_W    = 8;
    localparam int INIT_DIV = 199;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [DIV_W-1:0] dv = '0;
    logic             sdclk;
    logic             rise_stb;
    logic             fall_stb;
    logic             ack;
    logic             running;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    logic [4:0] exp_q[$];

    // Reference model: level, cycles left in this phase, active/pending div.
    bit         m_run = 1'b0;
    bit         m_lvl = 1'b0;
    int         m_left = 0;
    int         m_div = INIT_DIV;
    int         m_pv = INIT_DIV;
    bit         m_pend = 1'b0;
    logic [4:0] m_out = '0;

    sd_clk_gen #(
        .DIV_W   (DIV_W),
        .INIT_DIV(INIT_DIV)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .clk_en_i  (en),
        .div_i     (dv),
        .div_load_i(load),
        .SDCLK_o   (sdclk),
        .rise_stb_o(rise_stb),
        .fall_stb_o(fall_stb),
        .div_ack_o (ack),
        .running_o (running)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit r;
        bit f;
        bit a;
        bit ap;
        r  = 1'b0;
        f  = 1'b0;
        a  = 1'b0;
        ap = 1'b0;
        if (rst) begin
            m_run  = 1'b0;
            m_lvl  = 1'b0;
            m_left = 0;
            m_div  = INIT_DIV;
            m_pend = 1'b0;
        end else begin
            if (!m_run) begin
                ap = m_pend;
                if (ap) m_div = m_pv;
                if (en) begin
                    m_run  = 1'b1;
                    m_lvl  = 1'b0;
                    m_left = m_div;
                end
            end else if (!m_lvl && !en) begin
                m_run = 1'b0;
            end else if (m_left == 0) begin
                if (m_lvl) begin
                    f  = 1'b1;
                    ap = m_pend;
                    if (ap) m_div = m_pv;
                    if (!en) m_run = 1'b0;
                end else begin
                    r = 1'b1;
                end
                m_lvl  = !m_lvl;
                m_left = m_div;
            end else begin
                m_left = m_left - 1;
            end
            if (ap) begin
                m_pend = 1'b0;
                a      = 1'b1;
            end
            if (load) begin
                m_pv   = int'(dv);
                m_pend = 1'b1;
            end
        end
        m_out = {m_lvl, r, f, a, m_run};
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc_no++;
            model_step();
            exp_q.push_back(m_out);
        end
    end

    // Monitor: one expected vector per clock, compared just after the edge.
    initial begin
        logic [4:0] e;
        logic [4:0] g;
        forever begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty cycle=%0d", cyc_no);
            end else begin
                e = exp_q.pop_front();
                g = {sdclk, rise_stb, fall_stb, ack, running};
                if (g !== e) begin
                    n_bad++;
                    if (n_bad < 30)
                        $display("FAIL sb cycle=%0d got=%b want=%b (clk,rise,fall,ack,run)",
                                 cyc_no, g, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input int v);
        dv   = DIV_W'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // which: 0 rise, 1 fall, 2 ack, 3 SDCLK high. Returns cycle number or -1.
    task automatic wait_sig(input int which, input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if ((which == 0 && rise_stb) || (which == 1 && fall_stb) ||
                (which == 2 && ack) || (which == 3 && sdclk)) begin
                at = cyc_no;
                return;
            end
        end
    endtask

    function automatic int span(input int a, input int b);
        return (a < 0 || b < 0) ? -1 : b - a;
    endfunction

    initial begin
        int t0;
        int tr;
        int tf;
        int tx;

        cyc(3);
        rst = 1'b0;
        cyc(2);
        chk("reset_running", int'(running), 0);
        chk("reset_sdclk", int'(sdclk), 0);

        // Enable at INIT_DIV: 200-cycle latency, 200/200 duty.
        en = 1'b1;
        t0 = cyc_no + 1;
        wait_sig(0, 1000, tr);
        chk("first_rise", span(t0, tr), 200);
        wait_sig(1, 1000, tf);
        chk("high_len_init", span(tr, tf), 200);
        wait_sig(0, 1000, tx);
        chk("low_len_init", span(tf, tx), 200);
        tr = tx;

        // Two loads mid-high: the second overwrites the first.
        cyc(50);
        pulse_load(7);
        cyc(10);
        pulse_load(1);
        wait_sig(1, 1000, tf);
        chk("high_len_with_load", span(tr, tf), 200);
        chk("ack_with_fall", int'(ack), 1);
        wait_sig(0, 20, tr);
        chk("low_len_div1", span(tf, tr), 2);
        wait_sig(1, 20, tf);
        chk("high_len_div1", span(tr, tf), 2);

        // div 0, then stop while high: one more fall then STOP.
        pulse_load(0);
        wait_sig(2, 20, tx);
        chk("ack_div0_seen", int'(tx > 0), 1);
        cyc(6);
        wait_sig(3, 10, tx);
        en = 1'b0;
        @(negedge clk);
        chk("stop_high_fall", int'(fall_stb), 1);
        chk("stop_high_sdclk", int'(sdclk), 0);
        chk("stop_high_running", int'(running), 0);
        cyc(3);

        // D=3: stop while low, load 9 in STOP, restart.
        pulse_load(3);
        cyc(2);
        en = 1'b1;
        wait_sig(0, 50, tr);
        wait_sig(1, 50, tf);
        en = 1'b0;
        @(negedge clk);
        chk("stop_low_running", int'(running), 0);
        chk("stop_low_sdclk", int'(sdclk), 0);
        cyc(2);
        t0 = cyc_no;
        pulse_load(9);
        wait_sig(2, 10, tx);
        chk("stop_ack_latency", span(t0, tx), 2);
        en = 1'b1;
        t0 = cyc_no + 1;
        wait_sig(0, 100, tr);
        chk("restart_rise", span(t0, tr), 10);

        // Reset mid-high with a pending load, plus a load during reset.
        cyc(3);
        pulse_load(2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sdclk", int'(sdclk), 0);
        chk("rst_no_fall", int'(fall_stb), 0);
        pulse_load(4);
        rst = 1'b0;
        t0 = cyc_no + 1;
        wait_sig(0, 1000, tr);
        chk("post_rst_rise", span(t0, tr), 200);

        // One-cycle low on clk_en_i during high: cancelled stop.
        cyc(20);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        wait_sig(1, 1000, tf);
        chk("cancel_high_len", span(tr, tf), 200);
        chk("cancel_running", int'(running), 1);
        wait_sig(0, 1000, tx);
        chk("cancel_low_len", span(tf, tx), 200);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            en   = ($urandom_range(0, 19) != 0);
            load = ($urandom_range(0, 9) == 0);
            dv   = DIV_W'($urandom_range(0, 5));
            rst  = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst  = 1'b0;
        load = 1'b0;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
